// File: rtl/axi4_ram_responder.sv
// ---------------------------------------------------------------------------
// axi4_ram_responder
//
// AXI4 memory-mapped slave in front of an on-chip RAM of MEM_WORDS words of
// DATA_WIDTH bits. The read and write channels are served by two independent
// FSMs, each handling one burst at a time. INCR, FIXED and WRAP bursts are
// supported, as are narrow transfers and WSTRB byte enables.
//
// Ports
//   aclk, aresetn                    clock (rising edge) / async active-low reset
//   aw* (id, addr, len, size, burst) write address channel, awvalid/awready
//   wdata, wstrb, wlast              write data channel, wvalid/wready
//   bid, bresp                       write response channel, bvalid/bready
//   ar* (id, addr, len, size, burst) read address channel, arvalid/arready
//   rid, rdata, rresp, rlast         read data channel, rvalid/rready
//
// Every output is driven straight from a flop. All flops reset to zero, so
// the readies stay low during reset and rise on the first clock edge after
// release. The RAM array itself is never reset.
// ---------------------------------------------------------------------------
module axi4_ram_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 512
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam logic [2:0] MAX_SIZE = 3'(OFFS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

    // Address of the beat that follows 'addr'. Oversized transfers are clamped
    // to the bus width. WRAP only wraps for the legal lengths 2/4/8/16; any
    // other WRAP length, and the reserved burst type, advance like INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [2:0]            eff_size;
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] sum;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] result;
        logic                  wrap_ok;
        eff_size = (size > MAX_SIZE) ? MAX_SIZE : size;
        step     = ADDR_ONE << eff_size;
        sum      = addr + step;
        mask     = (({{(ADDR_WIDTH-8){1'b0}}, len} + ADDR_ONE) << eff_size) - ADDR_ONE;
        wrap_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        case (burst)
            2'b00:   result = addr;
            2'b01:   result = sum;
            2'b10: begin
                if (wrap_ok) begin
                    result = (addr & ~mask) | (sum & mask);
                end else begin
                    result = sum;
                end
            end
            default: result = sum;
        endcase
        return result;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

    // ---------------- write side ----------------
    w_state_t              w_state_r;
    w_state_t              w_state_s;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [ID_WIDTH-1:0]   aw_id_r;
    logic [ADDR_WIDTH-1:0] aw_addr_r;
    logic [7:0]            aw_len_r;
    logic [2:0]            aw_size_r;
    logic [1:0]            aw_burst_r;
    logic [7:0]            w_cnt_r;
    logic                  w_err_r;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  b_hs_s;
    logic                  w_last_beat_s;
    logic [ADDR_WIDTH-1:0] w_addr_nxt_s;

    // Write FSM next-state and handshake decode.
    always_comb begin
        aw_hs_s       = awvalid & awready_r;
        w_hs_s        = wvalid & wready_r;
        b_hs_s        = bvalid_r & bready;
        w_last_beat_s = (w_cnt_r == aw_len_r);
        w_addr_nxt_s  = next_addr(aw_addr_r, aw_len_r, aw_size_r, aw_burst_r);
        w_state_s     = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) w_state_s = W_DATA;
                else         w_state_s = W_IDLE;
            end
            W_DATA: begin
                // Only the beat count ends the burst; wlast is just audited.
                if (w_hs_s && w_last_beat_s) w_state_s = W_RESP;
                else                         w_state_s = W_DATA;
            end
            W_RESP: begin
                if (b_hs_s) w_state_s = W_IDLE;
                else        w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write FSM state, registered channel flags and burst bookkeeping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_r  <= W_IDLE;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            aw_id_r    <= '0;
            aw_addr_r  <= '0;
            aw_len_r   <= 8'd0;
            aw_size_r  <= 3'd0;
            aw_burst_r <= 2'd0;
            w_cnt_r    <= 8'd0;
            w_err_r    <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            awready_r <= (w_state_s == W_IDLE);
            wready_r  <= (w_state_s == W_DATA);
            bvalid_r  <= (w_state_s == W_RESP);
            if (aw_hs_s) begin
                aw_id_r    <= awid;
                aw_addr_r  <= awaddr;
                aw_len_r   <= awlen;
                aw_size_r  <= awsize;
                aw_burst_r <= awburst;
                w_cnt_r    <= 8'd0;
                w_err_r    <= 1'b0;
            end else if (w_hs_s) begin
                aw_addr_r <= w_addr_nxt_s;
                w_cnt_r   <= w_cnt_r + 8'd1;
                // wlast must appear exactly on the len-th beat.
                if (wlast != w_last_beat_s) w_err_r <= 1'b1;
            end
        end
    end

    // RAM write port: byte-lane merge under wstrb, unselected lanes untouched.
    always_ff @(posedge aclk) begin
        if (w_hs_s) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrb[b]) begin
                    mem_r[aw_addr_r[OFFS +: IDX_W]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read side ----------------
    r_state_t              r_state_r;
    r_state_t              r_state_s;
    logic                  arready_r;
    logic                  rvalid_r;
    logic                  rlast_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [ID_WIDTH-1:0]   ar_id_r;
    logic [ADDR_WIDTH-1:0] ar_addr_r;
    logic [7:0]            ar_len_r;
    logic [2:0]            ar_size_r;
    logic [1:0]            ar_burst_r;
    logic [7:0]            r_cnt_r;
    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic [ADDR_WIDTH-1:0] r_addr_nxt_s;

    // Read FSM next-state and handshake decode.
    always_comb begin
        ar_hs_s      = arvalid & arready_r;
        r_hs_s       = rvalid_r & rready;
        r_addr_nxt_s = next_addr(ar_addr_r, ar_len_r, ar_size_r, ar_burst_r);
        r_state_s    = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_s = R_FETCH;
                else         r_state_s = R_IDLE;
            end
            R_FETCH: r_state_s = R_DATA;
            R_DATA: begin
                if (r_hs_s && rlast_r) r_state_s = R_IDLE;
                else                   r_state_s = R_DATA;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read FSM state, RAM read register and beat sequencing. The RAM is read
    // with the already-advanced address on each R handshake so a new beat is
    // ready every cycle; without a handshake rdata/rlast simply hold.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_r  <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rdata_r    <= '0;
            ar_id_r    <= '0;
            ar_addr_r  <= '0;
            ar_len_r   <= 8'd0;
            ar_size_r  <= 3'd0;
            ar_burst_r <= 2'd0;
            r_cnt_r    <= 8'd0;
        end else begin
            r_state_r <= r_state_s;
            arready_r <= (r_state_s == R_IDLE);
            rvalid_r  <= (r_state_s == R_DATA);
            if (ar_hs_s) begin
                ar_id_r    <= arid;
                ar_addr_r  <= araddr;
                ar_len_r   <= arlen;
                ar_size_r  <= arsize;
                ar_burst_r <= arburst;
                r_cnt_r    <= 8'd0;
            end else if (r_state_r == R_FETCH) begin
                rdata_r <= mem_r[ar_addr_r[OFFS +: IDX_W]];
                rlast_r <= (ar_len_r == 8'd0);
            end else if (r_hs_s) begin
                if (rlast_r) begin
                    rlast_r <= 1'b0;
                end else begin
                    ar_addr_r <= r_addr_nxt_s;
                    rdata_r   <= mem_r[r_addr_nxt_s[OFFS +: IDX_W]];
                    r_cnt_r   <= r_cnt_r + 8'd1;
                    rlast_r   <= ((r_cnt_r + 8'd1) == ar_len_r);
                end
            end
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bid     = aw_id_r;
    assign bresp   = {w_err_r, 1'b0};
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rid     = ar_id_r;
    assign rdata   = rdata_r;
    assign rresp   = 2'b00;
    assign rlast   = rlast_r;

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Testbench for axi4_ram_responder: directed scenarios plus randomized bursts,
// checked against a byte-array memory model with burst addresses computed
// arithmetically from the burst rules.
module tb_axi4_ram_responder;

    localparam int RAM_BYTES = 4096;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = 4'd0;
    logic [15:0] awaddr = 16'd0;
    logic [7:0]  awlen = 8'd0;
    logic [2:0]  awsize = 3'd0;
    logic [1:0]  awburst = 2'd0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = 64'd0;
    logic [7:0]  wstrb = 8'd0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = 4'd0;
    logic [15:0] araddr = 16'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'd0;
    logic [1:0]  arburst = 2'd0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 aclk = ~aclk;

    axi4_ram_responder #(
        .DATA_WIDTH(64), .ADDR_WIDTH(16), .ID_WIDTH(4), .MEM_WORDS(512)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  model_mem [RAM_BYTES];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] rd_beats [256];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte address of beat i, straight from the burst definitions.
    function automatic int beat_addr(int start, int len, int size, int burst, int i);
        int nb, win, base, a;
        nb = (size > 3) ? 8 : (1 << size);
        if (burst == 0) begin
            a = start;
        end else if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            win  = (len + 1) * nb;
            base = (start / win) * win;
            a    = base + ((start - base + i * nb) % win);
        end else begin
            a = start + i * nb;
        end
        return a % 65536;
    endfunction

    function automatic logic [63:0] model_word(int a);
        logic [63:0] w;
        int idx;
        idx = a % RAM_BYTES;
        idx = idx - (idx % 8);
        for (int b = 0; b < 8; b++) w[b*8 +: 8] = model_mem[idx + b];
        return w;
    endfunction

    task automatic wait_cycle();
        @(posedge aclk);
        #1;
    endtask

    // Assert reset mid-transaction, check every output is zero, then release
    // and check the readies come up one edge later.
    task automatic do_abort(input string tag);
        aresetn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        #1;
        check_eq({tag, "_outs_zero"},
                 {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rlast, rdata},
                 128'd0);
        wait_cycle();
        wait_cycle();
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check_eq({tag, "_awready_still_low"}, awready, 1'b0);
        wait_cycle();
        check_eq({tag, "_readies_up"}, {awready, arready}, 2'b11);
    endtask

    task automatic axi_write(input logic [3:0] id, input int addr, input int len, input int size,
                             input int burst, input int wlast_beat, input int abort_beat,
                             input string tag);
        int   cyc, a;
        logic hs;
        awid = id; awaddr = addr[15:0]; awlen = len[7:0]; awsize = size[2:0];
        awburst = burst[1:0]; awvalid = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 200) begin
            hs = awready;
            wait_cycle();
            cyc++;
        end
        awvalid = 1'b0;
        if (!hs) begin
            check_eq({tag, "_aw_timeout"}, 1'b0, 1'b1);
            return;
        end
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_beat);
            if (i == abort_beat) begin
                do_abort(tag);
                return;
            end
            cyc = 0; hs = 1'b0;
            while (!hs && cyc < 200) begin
                hs = wready;
                wait_cycle();
                cyc++;
            end
            if (!hs) begin
                wvalid = 1'b0;
                check_eq({tag, "_w_timeout"}, 1'b0, 1'b1);
                return;
            end
            a = beat_addr(addr, len, size, burst, i) % RAM_BYTES;
            a = a - (a % 8);
            for (int b = 0; b < 8; b++) begin
                if (ws[i][b]) model_mem[a + b] = wd[i][b*8 +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1; cyc = 0; hs = 1'b0;
        while (!hs && cyc < 200) begin
            if (bvalid) begin
                check_eq({tag, "_bid"}, bid, id);
                check_eq({tag, "_bresp"}, bresp, (wlast_beat == len) ? 2'b00 : 2'b10);
                hs = 1'b1;
            end
            wait_cycle();
            cyc++;
        end
        bready = 1'b0;
        if (!hs) check_eq({tag, "_b_timeout"}, 1'b0, 1'b1);
        else     check_eq({tag, "_bvalid_drop"}, bvalid, 1'b0);
    endtask

    // bp = percentage of cycles with rready low (0 = always ready).
    task automatic axi_read(input logic [3:0] id, input int addr, input int len, input int size,
                            input int burst, input int bp, input int abort_beat,
                            input string tag);
        int   cyc, beat, first;
        logic hs;
        arid = id; araddr = addr[15:0]; arlen = len[7:0]; arsize = size[2:0];
        arburst = burst[1:0]; arvalid = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 200) begin
            hs = arready;
            wait_cycle();
            cyc++;
        end
        arvalid = 1'b0;
        if (!hs) begin
            check_eq({tag, "_ar_timeout"}, 1'b0, 1'b1);
            return;
        end
        beat = 0; cyc = 0; first = -1;
        while (beat <= len && cyc < 3000) begin
            rready = (bp == 0) ? 1'b1 : ($urandom_range(0, 99) >= bp);
            if (rvalid) begin
                if (first < 0) first = cyc;
                if (beat == abort_beat) begin
                    do_abort(tag);
                    return;
                end
                // Also covers stalls: while held, the beat must still match.
                check_eq({tag, "_rdata"}, rdata, model_word(beat_addr(addr, len, size, burst, beat)));
                check_eq({tag, "_rid_rresp"}, {rid, rresp}, {id, 2'b00});
                check_eq({tag, "_rlast"}, rlast, (beat == len));
                if (rready) begin
                    rd_beats[beat] = rdata;
                    beat++;
                end
            end
            wait_cycle();
            cyc++;
        end
        rready = 1'b0;
        if (beat <= len) begin
            check_eq({tag, "_r_timeout"}, 1'b0, 1'b1);
        end else begin
            check_eq({tag, "_first_latency"}, first, 1);
            if (bp == 0) check_eq({tag, "_b2b_cycles"}, cyc, len + 2);
            check_eq({tag, "_rvalid_drop"}, rvalid, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int burst, len, size, nb, addr;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("reset_outs_zero",
                 {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rlast, rdata},
                 128'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check_eq("reset_awready_low", awready, 1'b0);
        wait_cycle();
        check_eq("reset_readies_up", {awready, arready}, 2'b11);

        // 1: 128-beat INCR write, beat k = 16-bit values 4k..4k+3, read back.
        for (int k = 0; k < 128; k++) begin
            wd[k] = {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)};
            ws[k] = 8'hFF;
        end
        axi_write(4'd0, 0, 127, 3, 1, 127, -1, "t1_wr");
        axi_read(4'd1, 0, 127, 3, 1, 0, -1, "t1_rd");
        check_eq("t1_beat127", rd_beats[127], 64'h01FF_01FE_01FD_01FC);

        // Fill the rest of the RAM so every address has known content.
        for (int r = 1; r < 4; r++) begin
            for (int k = 0; k < 128; k++) begin
                wd[k] = {$urandom, $urandom};
                ws[k] = 8'hFF;
            end
            axi_write(4'(r), r * 1024, 127, 3, 1, 127, -1, "fill");
        end

        // 2: narrow 2-byte write with wstrb=0x03 at addr 8.
        wd[0] = {$urandom, $urandom};
        wd[0][15:0] = 16'h0800;
        ws[0] = 8'h03;
        axi_write(4'd2, 8, 0, 1, 1, 0, -1, "t2_wr");
        axi_read(4'd3, 8, 0, 3, 1, 0, -1, "t2_rd");
        check_eq("t2_word", rd_beats[0], 64'h0007_0006_0005_0800);

        // 3: WRAP len3 at 0x18 writes A,B,C,D; INCR read from 0 gives B,C,D,A.
        wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; wd[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        wd[2] = 64'hCCCC_CCCC_CCCC_CCCC; wd[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        for (int k = 0; k < 4; k++) ws[k] = 8'hFF;
        axi_write(4'd4, 'h18, 3, 3, 2, 3, -1, "t3_wr");
        axi_read(4'd5, 0, 3, 3, 1, 0, -1, "t3_rd");
        check_eq("t3_b0", rd_beats[0], 64'hBBBB_BBBB_BBBB_BBBB);
        check_eq("t3_b1", rd_beats[1], 64'hCCCC_CCCC_CCCC_CCCC);
        check_eq("t3_b2", rd_beats[2], 64'hDDDD_DDDD_DDDD_DDDD);
        check_eq("t3_b3", rd_beats[3], 64'hAAAA_AAAA_AAAA_AAAA);

        // 4: 16-beat read with backpressure, then back-to-back.
        axi_read(4'd6, 'h400, 15, 3, 1, 40, -1, "t4_bp");
        axi_read(4'd7, 'h400, 15, 3, 1, 0, -1, "t4_b2b");

        // 5: early wlast -> still 4 beats, SLVERR.
        for (int k = 0; k < 4; k++) begin
            wd[k] = {$urandom, $urandom};
            ws[k] = 8'hFF;
        end
        axi_write(4'd8, 'h300, 3, 3, 1, 1, -1, "t5_wr");
        axi_read(4'd9, 'h300, 3, 3, 1, 0, -1, "t5_rd");

        // 6: reset during beat 5 of a write and of a read, then fresh pair.
        for (int k = 0; k < 16; k++) begin
            wd[k] = {$urandom, $urandom};
            ws[k] = 8'hFF;
        end
        axi_write(4'd10, 'h200, 15, 3, 1, 15, 5, "t6_wr_abort");
        axi_read(4'd11, 'h200, 15, 3, 1, 0, -1, "t6_rd_partial");
        axi_read(4'd12, 'h200, 15, 3, 1, 0, 5, "t6_rd_abort");
        wd[0] = {$urandom, $urandom};
        ws[0] = 8'hFF;
        axi_write(4'd13, 'h40, 0, 3, 1, 0, -1, "t6_wr_fresh");
        axi_read(4'd14, 'h40, 0, 3, 1, 0, -1, "t6_rd_fresh");

        // Both channels active at once on disjoint regions.
        for (int k = 0; k < 16; k++) begin
            wd[k] = {$urandom, $urandom};
            ws[k] = 8'($urandom);
        end
        fork
            axi_write(4'd3, 'h800, 15, 3, 1, 15, -1, "par_wr");
            axi_read(4'd5, 'h000, 15, 3, 1, 0, -1, "par_rd");
        join
        axi_read(4'd6, 'h800, 15, 3, 1, 0, -1, "par_chk");

        // Randomized bursts: write then read back with the same parameters.
        for (int n = 0; n < 30; n++) begin
            burst = $urandom_range(0, 2);
            size  = $urandom_range(0, 4);
            len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
            nb    = (size > 3) ? 8 : (1 << size);
            addr  = ($urandom_range(0, 65535) / nb) * nb;
            for (int k = 0; k <= len; k++) begin
                wd[k] = {$urandom, $urandom};
                ws[k] = 8'($urandom);
            end
            axi_write(4'($urandom), addr, len, size, burst, len, -1, "rnd_wr");
            axi_read(4'($urandom), addr, len, size, burst, ($urandom_range(0, 1) != 0) ? 30 : 0,
                     -1, "rnd_rd");
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
